// File: rtl/polyline_sequencer.sv
// Vertex buffer plus segment sequencer: stores up to DEPTH points, then walks them pairwise,
// starting the line-drawing engine once per segment and optionally closing the loop.
module polyline_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          pt_valid,
    input  logic [8:0]    pt_x,
    input  logic [7:0]    pt_y,
    output logic          pt_ready,
    input  logic          draw_go,
    input  logic          close_loop,
    output logic          lda_go,
    output logic [8:0]    lda_x0,
    output logic [8:0]    lda_x1,
    output logic [7:0]    lda_y0,
    output logic [7:0]    lda_y1,
    input  logic          lda_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t        state_q;
    logic [AW:0]   count_q;
    logic [AW:0]   seg_q;
    logic          close_q;
    logic          closing_q;
    logic          lda_go_q;
    logic          done_q;
    logic          err_q;
    logic [8:0]    x0_q, x1_q;
    logic [7:0]    y0_q, y1_q;

    logic [8:0]    bx_q [DEPTH];
    logic [7:0]    by_q [DEPTH];

    logic          accept;
    logic [AW:0]   count_d;
    logic [AW:0]   seg_plus;
    logic          more_segs;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] seg_idx;
    logic [AW-1:0] nxt_idx;
    logic [AW-1:0] last_idx;
    logic [8:0]    x1_start;
    logic [7:0]    y1_start;

    // Handshake: a vertex transfers on any clock edge where pt_valid and pt_ready are both high.
    assign pt_ready  = (state_q == S_IDLE) && (count_q < (AW+1)'(DEPTH));
    assign accept    = pt_valid && pt_ready;
    assign count_d   = count_q + {{AW{1'b0}}, accept};
    assign wr_idx    = count_q[AW-1:0];
    assign seg_plus  = seg_q + (AW+1)'(1);
    assign more_segs = seg_plus < count_q;
    assign seg_idx   = seg_q[AW-1:0];
    assign nxt_idx   = seg_plus[AW-1:0];
    assign last_idx  = AW'(count_q - (AW+1)'(1));

    // A vertex landing in the same cycle as draw_go can only be vertex 1 of the first segment.
    assign x1_start  = (accept && count_q == (AW+1)'(1)) ? pt_x : bx_q[1];
    assign y1_start  = (accept && count_q == (AW+1)'(1)) ? pt_y : by_q[1];

    always_ff @(posedge clock) begin
        if (accept) begin
            bx_q[wr_idx] <= pt_x;
            by_q[wr_idx] <= pt_y;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            seg_q     <= '0;
            close_q   <= 1'b0;
            closing_q <= 1'b0;
            lda_go_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
        end else begin
            lda_go_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    count_q <= count_d;
                    if (draw_go) begin
                        if (count_d < (AW+1)'(2)) begin
                            err_q <= 1'b1;
                        end else begin
                            close_q   <= close_loop;
                            closing_q <= 1'b0;
                            seg_q     <= (AW+1)'(1);
                            x0_q      <= bx_q[0];
                            y0_q      <= by_q[0];
                            x1_q      <= x1_start;
                            y1_q      <= y1_start;
                            lda_go_q  <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (lda_done) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (!closing_q && more_segs) begin
                        seg_q    <= seg_plus;
                        x0_q     <= bx_q[seg_idx];
                        y0_q     <= by_q[seg_idx];
                        x1_q     <= bx_q[nxt_idx];
                        y1_q     <= by_q[nxt_idx];
                        lda_go_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end else if (!closing_q && close_q && count_q >= (AW+1)'(3)) begin
                        closing_q <= 1'b1;
                        x0_q      <= bx_q[last_idx];
                        y0_q      <= by_q[last_idx];
                        x1_q      <= bx_q[0];
                        y1_q      <= by_q[0];
                        lda_go_q  <= 1'b1;
                        state_q   <= S_ISSUE;
                    end else begin
                        done_q  <= 1'b1;
                        count_q <= '0;
                        state_q <= S_FIN;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lda_go    = lda_go_q;
    assign lda_x0    = x0_q;
    assign lda_y0    = y0_q;
    assign lda_x1    = x1_q;
    assign lda_y1    = y1_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_polyline_sequencer.sv
// Bench for polyline_sequencer: a point-list model derives the expected segment sequence,
// with a vector table for buffer fill, directed corner sequences and randomized polylines.
module tb_polyline_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       pt_valid, draw_go, close_loop, lda_done;
  logic [8:0] pt_x;
  logic [7:0] pt_y;
  logic       pt_ready, lda_go, busy, done, err;
  logic [8:0] lda_x0, lda_x1;
  logic [7:0] lda_y0, lda_y1;
  logic [3:0] count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [16:0] pts_q[$];
  logic [33:0] exp_q[$];

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic       exp_ready;
    logic [3:0] exp_count;
  } vec_t;
  vec_t vecs[9];

  polyline_sequencer #(.DEPTH(8), .AW(3)) dut (
    .clock(clock), .resetN(resetN),
    .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
    .draw_go(draw_go), .close_loop(close_loop),
    .lda_go(lda_go), .lda_x0(lda_x0), .lda_x1(lda_x1), .lda_y0(lda_y0), .lda_y1(lda_y1),
    .lda_done(lda_done), .busy(busy), .done(done), .err(err), .count(count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: one vertex write, checked against the model's buffer occupancy
  task automatic write_pt(input logic [8:0] x, input logic [7:0] y);
    chk("pt_ready", 34'(pt_ready), 34'(pts_q.size() < 8));
    pt_valid = 1'b1;
    pt_x = x;
    pt_y = y;
    tick();
    pt_valid = 1'b0;
    if (pts_q.size() < 8) pts_q.push_back({x, y});
    chk("count_after_write", 34'(count), 34'(pts_q.size()));
  endtask

  // driver + scoreboard: draw_go (optionally with a same-cycle vertex), then serve every lda_go
  task automatic run_draw(input bit c, input bit wp, input logic [8:0] wx, input logic [7:0] wy);
    automatic int n;
    automatic int d;
    automatic logic [33:0] cur;
    if (wp) begin
      pt_valid = 1'b1;
      pt_x = wx;
      pt_y = wy;
      if (pts_q.size() < 8) pts_q.push_back({wx, wy});
    end
    n = pts_q.size();
    exp_q.delete();
    for (int i = 1; i < n; i++) exp_q.push_back({pts_q[i-1], pts_q[i]});
    if (c && n >= 3) exp_q.push_back({pts_q[n-1], pts_q[0]});
    draw_go = 1'b1;
    close_loop = c;
    tick();
    draw_go = 1'b0;
    close_loop = 1'b0;
    pt_valid = 1'b0;
    if (exp_q.size() == 0) begin
      chk("err_pulse", 34'(err), 34'd1);
      chk("err_no_go", 34'(lda_go), 34'd0);
      chk("err_not_busy", 34'(busy), 34'd0);
      chk("err_count_kept", 34'(count), 34'(n));
      tick();
      chk("err_one_cycle", 34'(err), 34'd0);
      chk("err_no_go_late", 34'(lda_go), 34'd0);
      return;
    end
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("lda_go", 34'(lda_go), 34'd1);
      chk("segment", {lda_x0, lda_y0, lda_x1, lda_y1}, cur);
      chk("busy", 34'(busy), 34'd1);
      tick();
      chk("go_one_cycle", 34'(lda_go), 34'd0);
      d = $urandom_range(0, 3);
      repeat (d) begin
        tick();
        chk("wait_hold", {lda_x0, lda_y0, lda_x1, lda_y1}, cur);
        chk("wait_no_go", 34'(lda_go), 34'd0);
      end
      lda_done = 1'b1;
      tick();
      lda_done = 1'b0;
      chk("next_no_go", 34'(lda_go), 34'd0);
      chk("next_no_done", 34'(done), 34'd0);
      tick();
    end
    chk("done", 34'(done), 34'd1);
    chk("done_count0", 34'(count), 34'd0);
    chk("done_no_go", 34'(lda_go), 34'd0);
    pts_q.delete();
    tick();
    chk("done_one_cycle", 34'(done), 34'd0);
    chk("idle_not_busy", 34'(busy), 34'd0);
    chk("idle_ready", 34'(pt_ready), 34'd1);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i].x = 9'(20 + 30 * i);
      vecs[i].y = 8'(5 + 25 * i);
      vecs[i].exp_ready = (i < 8);
      vecs[i].exp_count = (i < 8) ? 4'(i + 1) : 4'd8;
    end

    resetN = 1'b0;
    pt_valid = 1'b0; pt_x = '0; pt_y = '0;
    draw_go = 1'b0; close_loop = 1'b0; lda_done = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    tick();

    chk("rst_count", 34'(count), 34'd0);
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_go", 34'(lda_go), 34'd0);
    chk("rst_done", 34'(done), 34'd0);
    chk("rst_err", 34'(err), 34'd0);
    chk("rst_ready", 34'(pt_ready), 34'd1);
    chk("rst_coords", {lda_x0, lda_y0, lda_x1, lda_y1}, 34'd0);

    // open polyline of three vertices
    write_pt(9'd10, 8'd10);
    write_pt(9'd100, 8'd10);
    write_pt(9'd100, 8'd50);
    run_draw(1'b0, 1'b0, '0, '0);

    // same vertices, closed
    write_pt(9'd10, 8'd10);
    write_pt(9'd100, 8'd10);
    write_pt(9'd100, 8'd50);
    run_draw(1'b1, 1'b0, '0, '0);

    // underflow with zero then one vertex
    run_draw(1'b0, 1'b0, '0, '0);
    write_pt(9'd7, 8'd9);
    run_draw(1'b1, 1'b0, '0, '0);

    // same-cycle vertex and draw_go
    run_draw(1'b1, 1'b1, 9'd300, 8'd200);

    // closed with exactly two vertices: still one segment
    write_pt(9'd1, 8'd2);
    write_pt(9'd3, 8'd4);
    run_draw(1'b1, 1'b0, '0, '0);

    // buffer fill table
    foreach (vecs[i]) begin
      chk("tbl_ready", 34'(pt_ready), 34'(vecs[i].exp_ready));
      write_pt(vecs[i].x, vecs[i].y);
      chk("tbl_count", 34'(count), 34'(vecs[i].exp_count));
    end
    run_draw(1'b0, 1'b0, '0, '0);

    // reset while waiting on the second segment
    write_pt(9'd10, 8'd10);
    write_pt(9'd100, 8'd10);
    write_pt(9'd100, 8'd50);
    draw_go = 1'b1;
    tick();
    draw_go = 1'b0;
    tick();
    lda_done = 1'b1;
    tick();
    lda_done = 1'b0;
    tick();
    chk("rst5_second_go", 34'(lda_go), 34'd1);
    tick();
    resetN = 1'b0;
    #1;
    chk("rst5_busy", 34'(busy), 34'd0);
    chk("rst5_count", 34'(count), 34'd0);
    chk("rst5_go", 34'(lda_go), 34'd0);
    chk("rst5_coords", {lda_x0, lda_y0, lda_x1, lda_y1}, 34'd0);
    pts_q.delete();
    @(posedge clock);
    #1 resetN = 1'b1;
    lda_done = 1'b1;
    tick();
    lda_done = 1'b0;
    chk("rst5_late_done_go", 34'(lda_go), 34'd0);
    chk("rst5_late_busy", 34'(busy), 34'd0);
    tick();
    chk("rst5_late_no_done", 34'(done), 34'd0);
    chk("rst5_late_idle", 34'(busy), 34'd0);
    chk("rst5_ready", 34'(pt_ready), 34'd1);

    // randomized polylines
    for (int it = 0; it < 25; it++) begin
      automatic int nw = $urandom_range(0, 9);
      automatic bit wp = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < nw; k++)
        write_pt(9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
      run_draw(1'($urandom_range(0, 1)), wp,
               9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
